// File: rtl/exhaustive_vector_checker.sv
// exhaustive_vector_checker: sweeps every WIDTH-bit vector into a combinational DUT and checks its output against a reduction
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            run request, accepted only when idle or done
//   mode             expected function: 00 xor, 01 and, 10 or, 11 xnor (latched at start)
//   dut_out          DUT output under test
//   stim             vector driven to the DUT
//   busy, done, pass run status; pass = done with no mismatches
//   err_cnt          saturating mismatch count
//   first_err_vec    stim of the first mismatch, valid when first_err_valid
module exhaustive_vector_checker #(
  parameter int WIDTH = 2,
  parameter int DWELL = 15,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_err_vec,
  output logic             first_err_valid
);
  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] HOLD_END = DW'(DWELL > 1 ? DWELL - 2 : 0);
  // SAMPLE is the last cycle of each hold, so with DWELL=1 the HOLD state is skipped entirely
  localparam state_t FIRST = DWELL == 1 ? SAMPLE : HOLD;
  state_t state, state_nxt;
  logic [DW-1:0] dwell;
  logic [1:0] mode_q;
  logic go, expected, mismatch;
  assign go = start && (state == IDLE || state == DONE);
  assign expected = mode_q == 2'b00 ? ^stim : mode_q == 2'b01 ? &stim : mode_q == 2'b10 ? |stim : ~^stim;
  assign mismatch = state == SAMPLE && dut_out != expected;
  assign pass = done && err_cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = go ? FIRST : state;
      HOLD: state_nxt = dwell == HOLD_END ? SAMPLE : HOLD;
      SAMPLE: state_nxt = &stim ? DONE : FIRST;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      dwell <= '0;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_cnt <= '0;
      first_err_vec <= '0;
      first_err_valid <= 1'b0;
    end else if (go) begin
      mode_q <= mode;
      dwell <= '0;
      stim <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      err_cnt <= '0;
      first_err_vec <= '0;
      first_err_valid <= 1'b0;
    end else if (state == HOLD) begin
      dwell <= dwell + 1'b1;
    end else if (state == SAMPLE) begin
      dwell <= '0;
      if (mismatch && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      if (mismatch && !first_err_valid) begin
        first_err_vec <= stim;
        first_err_valid <= 1'b1;
      end
      if (&stim) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        stim <= stim + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// tb_exhaustive_vector_checker: randomized self-checking bench against a popcount-based reference model
module tb_exhaustive_vector_checker;
  localparam int W = 2;
  localparam int DW = 15;
  localparam int NV = 1 << W;
  localparam int LAT = NV * DW;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  int kind = 0;
  logic [NV-1:0] flip = '0;
  logic [W-1:0] stim, stim_s, fev, fev_s;
  logic busy, done, pass, fevv, d_out, busy_s, done_s, pass_s, fevv_s, s_out;
  logic [15:0] err;
  logic [0:0] err_s;
  int errors = 0, checks = 0;
  function automatic logic dut_fn(input logic [W-1:0] s, input int k, input logic [NV-1:0] f);
    return k == 0 ? ^s : k == 1 ? 1'b0 : k == 2 ? 1'b1 : (^s ^ f[s]);
  endfunction
  assign d_out = dut_fn(stim, kind, flip);
  assign s_out = dut_fn(stim_s, kind, flip);
  exhaustive_vector_checker #(.WIDTH(W), .DWELL(DW), .ERR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(d_out), .stim(stim), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err), .first_err_vec(fev), .first_err_valid(fevv));
  exhaustive_vector_checker #(.WIDTH(W), .DWELL(DW), .ERR_W(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dut_out(s_out), .stim(stim_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .err_cnt(err_s), .first_err_vec(fev_s), .first_err_valid(fevv_s));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [1:0] m, output int ne, output int fv);
    ne = 0;
    fv = -1;
    for (int v = 0; v < NV; v++) begin
      int pc;
      logic e;
      pc = $countones(v);
      e = m == 0 ? pc % 2 == 1 : m == 1 ? pc == W : m == 2 ? pc > 0 : pc % 2 == 0;
      if (dut_fn(W'(v), kind, flip) != e) begin
        ne++;
        if (fv < 0) fv = v;
      end
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_stim"}, {stim, stim_s}, 0);
    chk({tag, "_flags"}, {busy, done, pass, fevv, busy_s, done_s, pass_s, fevv_s}, 0);
    chk({tag, "_err"}, {err, err_s}, 0);
    chk({tag, "_fev"}, {fev, fev_s}, 0);
  endtask
  task automatic run(input string tag, input logic [1:0] m, input int k, input logic [NV-1:0] f,
                     input int ign_at, input int rst_at);
    int n, ne, fv;
    kind = k;
    flip = f;
    mode = m;
    model(m, ne, fv);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    mode = ~m;
    chk({tag, "_c0_busy"}, {busy, done, busy_s}, 3'b101);
    chk({tag, "_c0_clear"}, {stim, err, fevv, err_s, fevv_s}, 0);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      start = n == ign_at;
      if (n == rst_at) begin
        rst_n = 0;
        #1;
        chk_reset({tag, "_abort"});
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_idle_after_rst"}, {busy, done}, 0);
        return;
      end
      if (n < LAT) chk({tag, "_stim"}, stim, n / DW);
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_done"}, {busy, done, stim, busy_s, done_s}, {2'b01, W'(NV - 1), 2'b01});
    chk({tag, "_err"}, err, ne);
    chk({tag, "_pass"}, pass, ne == 0);
    chk({tag, "_fevv"}, fevv, fv >= 0);
    chk({tag, "_fev"}, fev, fv >= 0 ? fv : 0);
    chk({tag, "_sat_err"}, err_s, ne > 0);
    chk({tag, "_sat_fev"}, {fevv_s, fev_s}, {fv >= 0, W'(fv >= 0 ? fv : 0)});
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, {done, stim}, {1'b1, W'(NV - 1)});
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("idle");
    run("xor_ideal", 2'b00, 0, '0, -1, -1);
    run("stuck0", 2'b00, 1, '0, -1, -1);
    run("and_vs_xor", 2'b01, 0, '0, -1, -1);
    run("start_ignored", 2'b00, 0, '0, 20, -1);
    run("abort", 2'b00, 0, '0, -1, 30);
    run("after_abort", 2'b00, 0, '0, -1, -1);
    run("stuck1_sat", 2'b00, 2, '0, -1, -1);
    run("stuck1_rerun", 2'b00, 2, '0, -1, -1);
    run("or_ideal", 2'b10, 0, '0, -1, -1);
    run("xnor_ideal", 2'b11, 0, '0, -1, -1);
    for (int i = 0; i < 10; i++)
      run("rand", 2'($urandom), 3, NV'($urandom), $urandom_range(0, 3) == 0 ? int'($urandom_range(1, LAT - 1)) : -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
